// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM states and round-robin helper
package mem_port_arbiter_pkg;
   localparam int ADDR_W      = 14;
   localparam int DATA_W      = 16;
   localparam int BRAM_ADDR_W = 8;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
      return &req ? (last_grant ? 2'b01 : 2'b10) : req;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's command/response bundle
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int SEL_W = 5
);
   logic              req;
   logic              we;
   logic              spram;
   logic [SEL_W-1:0]  sel;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              lock;
   logic              ack;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   modport master (output req, we, spram, sel, addr, wdata, lock, input ack, rvalid, rdata);
   modport slave  (input req, we, spram, sel, addr, wdata, lock, output ack, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// mem_port_arbiter_rr_arb2: two-way round-robin grant with lock reservation
module mem_port_arbiter_rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       lock_vld,
   input  logic       lock_own,
   input  logic       en,
   output logic [1:0] gnt
);
   logic last_grant;
   // a live lock reserves the port for its owner; otherwise ties alternate
   always_comb gnt = lock_vld ? (lock_own ? {req[1], 1'b0} : {1'b0, req[0]}) : rr_pick(req, last_grant);
   // remember the latest winner so the next tie goes to the other side
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) last_grant <= 1'b1;
      else if (en && |gnt) last_grant <= gnt[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one BRAM/SPRAM port between host FSM (r0) and NN engine (r1)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_SELECT_BITS = 5,
   parameter int RD_LATENCY      = 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   mem_port_arbiter_if.slave          r0,
   mem_port_arbiter_if.slave          r1,
   input  logic [DATA_W-1:0]          mem_out,
   output logic [MEM_SELECT_BITS-1:0] mem_select,
   output logic [BRAM_ADDR_W-1:0]     mem_addr,
   output logic [ADDR_W-1:0]          sp_addr,
   output logic [DATA_W-1:0]          mem_in,
   output logic                       rd_en,
   output logic                       wr_en,
   output logic                       bram_or_spram
);
   state_t                     state, state_nx;
   logic [1:0]                 gnt, ack;
   logic                       take, last, owner, cmd_we, cmd_lock, lock_vld, lock_own;
   logic                       we_w, spram_w, lock_w;
   logic [MEM_SELECT_BITS-1:0] sel_w;
   logic [ADDR_W-1:0]          addr_w;
   logic [DATA_W-1:0]          wdata_w, rdata0_q, rdata1_q;
   logic [1:0]                 cnt;
   mem_port_arbiter_rr_arb2 u_arb (
      .clk      (clk),
      .resetn   (resetn),
      .req      ({r1.req, r0.req}),
      .lock_vld (lock_vld),
      .lock_own (lock_own),
      .en       (state == ST_IDLE),
      .gnt      (gnt)
   );
   // winner's command fields and the FSM successor state
   always_comb begin
      take     = (state == ST_IDLE) && |gnt;
      last     = (state == ST_WAIT) && (cnt == 2'(RD_LATENCY - 1));
      we_w     = gnt[1] ? r1.we : r0.we;
      spram_w  = gnt[1] ? r1.spram : r0.spram;
      lock_w   = gnt[1] ? r1.lock : r0.lock;
      sel_w    = gnt[1] ? r1.sel : r0.sel;
      addr_w   = gnt[1] ? r1.addr : r0.addr;
      wdata_w  = gnt[1] ? r1.wdata : r0.wdata;
      state_nx = state == ST_IDLE  ? (take ? ST_ISSUE : ST_IDLE) :
                 state == ST_ISSUE ? (cmd_we ? ST_IDLE : ST_WAIT) :
                 state == ST_WAIT  ? (last ? ST_IDLE : ST_WAIT) : ST_IDLE;
   end
   // FSM state register
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= ST_IDLE;
      else state <= state_nx;
   // command register; memory-side fields hold between commands
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cmd_we        <= 1'b0;
         cmd_lock      <= 1'b0;
         owner         <= 1'b0;
         mem_select    <= '0;
         mem_addr      <= '0;
         sp_addr       <= '0;
         mem_in        <= '0;
         bram_or_spram <= 1'b0;
      end else if (take) begin
         cmd_we        <= we_w;
         cmd_lock      <= lock_w;
         owner         <= gnt[1];
         mem_select    <= sel_w;
         mem_addr      <= addr_w[BRAM_ADDR_W-1:0];
         sp_addr       <= addr_w;
         mem_in        <= wdata_w;
         bram_or_spram <= spram_w;
      end
   // one-cycle strobes and ack, high during ISSUE
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         rd_en <= 1'b0;
         wr_en <= 1'b0;
         ack   <= 2'b00;
      end else begin
         rd_en <= take & ~we_w;
         wr_en <= take & we_w;
         ack   <= take ? gnt : 2'b00;
      end
   // lock reservation is decided by the command being issued
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         lock_vld <= 1'b0;
         lock_own <= 1'b0;
      end else if (state == ST_ISSUE) begin
         lock_vld <= cmd_lock;
         lock_own <= owner;
      end
   // read latency counter, running only in WAIT
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt <= 2'd0;
      else cnt <= (state == ST_WAIT) ? cnt + 2'd1 : 2'd0;
   // per-requester read data holding registers
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (last) begin
         rdata0_q <= owner ? rdata0_q : mem_out;
         rdata1_q <= owner ? mem_out : rdata1_q;
      end
   assign r0.ack    = ack[0];
   assign r1.ack    = ack[1];
   assign r0.rvalid = last & ~owner;
   assign r1.rvalid = last & owner;
   assign r0.rdata  = r0.rvalid ? mem_out : rdata0_q;
   assign r1.rdata  = r1.rvalid ? mem_out : rdata1_q;
endmodule
